alu_divseq: RTL and testbench

Multi-cycle 32-bit divide/remainder sequencer for the robin SoC. It produces quotient and remainder by driving the shared combinational alu with one OP_SUB per cycle: restoring division, 32 iterations, plus optional signed pre- and post-negation. It requests the alu from the CPU-side arbiter with `alu_req` and stalls whenever `alu_gnt` is low. The CPU starts it through a start/valid handshake.

---
 rtl/alu_divseq_pkg.sv | 31 +++
 rtl/alu_divseq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_divseq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_divseq_pkg.sv
// Shared types and constants for the divide/remainder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_divseq_pkg;

    // Alu opcodes already used by the shared combinational alu.
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;

    // Iteration count of the restoring loop, loaded into the down-counter.
    localparam logic [4:0] LOOP_LAST = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREA  = 3'd1,
        ST_PREB  = 3'd2,
        ST_LOOP  = 3'd3,
        ST_POSTQ = 3'd4,
        ST_POSTR = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Borrow out of a 32-bit subtract a - b, recovered from the operand and
    // result sign bits because the alu does not export its carry.
    function automatic logic sub_borrow(input logic a_msb,
                                        input logic b_msb,
                                        input logic c_msb);
        return (~a_msb & b_msb) | (~(a_msb ^ b_msb) & c_msb);
    endfunction

endpackage

// File: rtl/alu_divseq.sv
// Multi-cycle 32-bit divide/remainder using the shared alu for one subtract per cycle.
// Latency: unsigned 33, signed 37, divide-by-zero 1 cycle from start, plus one per ungranted cycle.
// Backpressure: alu_gnt low freezes state, counter, data and alu operands; start ignored while busy.
module alu_divseq
    import alu_divseq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dbz,
    output logic        valid,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;     // dividend magnitude, shifted into the quotient
    logic [31:0] div_q, div_d;     // divisor magnitude
    logic [31:0] rem_q, rem_d;     // partial remainder
    logic        sa_q, sa_d;       // dividend negative (signed mode only)
    logic        sb_q, sb_d;       // divisor negative (signed mode only)
    logic        sgn_q, sgn_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic [31:0] x;                // shifted partial remainder for this step
    logic        carry;            // bit shifted out of the remainder
    logic        ge;               // x >= divisor, i.e. quotient bit

    assign x     = {rem_q[30:0], dvd_q[31]};
    assign carry = rem_q[31];
    assign ge    = carry | ~sub_borrow(x[31], div_q[31], alu_c[31]);

    // Alu operand selection: purely a function of state so operands hold during a stall.
    always_comb begin
        alu_a   = 32'h0;
        alu_b   = 32'h0;
        alu_req = 1'b0;
        unique case (state_q)
            ST_PREA: begin
                alu_b   = dvd_q;
                alu_req = 1'b1;
            end
            ST_PREB: begin
                alu_b   = div_q;
                alu_req = 1'b1;
            end
            ST_LOOP: begin
                alu_a   = x;
                alu_b   = div_q;
                alu_req = 1'b1;
            end
            ST_POSTQ: begin
                alu_b   = dvd_q;
                alu_req = 1'b1;
            end
            ST_POSTR: begin
                alu_b   = rem_q;
                alu_req = 1'b1;
            end
            default: begin
                alu_a   = 32'h0;
                alu_b   = 32'h0;
                alu_req = 1'b0;
            end
        endcase
        alu_op = alu_req ? OP_SUB : OP_NONE;
    end

    // Next-state and datapath: every step other than IDLE/DONE advances only on a granted cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        div_d       = div_q;
        rem_d       = rem_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sgn_d       = sgn_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sgn_d = is_signed;
                    sa_d  = dividend[31] & is_signed;
                    sb_d  = divisor[31] & is_signed;
                    div_d = divisor;
                    cnt_d = LOOP_LAST;
                    if (divisor == 32'h0) begin
                        // Results are staged in dvd/rem so the DONE capture below is uniform.
                        dvd_d   = 32'hFFFF_FFFF;
                        rem_d   = dividend;
                        state_d = ST_DONE;
                    end else begin
                        dvd_d   = dividend;
                        rem_d   = 32'h0;
                        state_d = is_signed ? ST_PREA : ST_LOOP;
                    end
                end
            end
            ST_PREA: begin
                if (alu_gnt) begin
                    if (sa_q) begin
                        dvd_d = alu_c;
                    end
                    state_d = ST_PREB;
                end
            end
            ST_PREB: begin
                if (alu_gnt) begin
                    if (sb_q) begin
                        div_d = alu_c;
                    end
                    state_d = ST_LOOP;
                end
            end
            ST_LOOP: begin
                if (alu_gnt) begin
                    rem_d = ge ? alu_c : x;
                    dvd_d = {dvd_q[30:0], ge};
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = sgn_q ? ST_POSTQ : ST_DONE;
                    end
                end
            end
            ST_POSTQ: begin
                if (alu_gnt) begin
                    if (sa_q ^ sb_q) begin
                        dvd_d = alu_c;
                    end
                    state_d = ST_POSTR;
                end
            end
            ST_POSTR: begin
                if (alu_gnt) begin
                    // Remainder takes the dividend's sign.
                    if (sa_q) begin
                        rem_d = alu_c;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results are captured on the edge entering DONE; only IDLE jumps straight there.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            quotient_d  = dvd_d;
            remainder_d = rem_d;
            dbz_d       = (state_q == ST_IDLE);
        end

        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any operation without a valid pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            dvd_q       <= 32'h0;
            div_q       <= 32'h0;
            rem_q       <= 32'h0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            sgn_q       <= 1'b0;
            quotient_q  <= 32'h0;
            remainder_q <= 32'h0;
            dbz_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sgn_q       <= sgn_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_divseq.sv
// Scoreboard bench for alu_divseq with a behavioural alu in the loop.
// Latency: checks the exact valid cycle of each operation.
// Backpressure: exercises alu_gnt stalls and start while busy.
module tb_alu_divseq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'h0;
    logic [31:0] divisor = 32'h0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_op;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [31:0] quotient, remainder;
    logic        dbz, valid, busy;

    alu_divseq dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .alu_req   (alu_req),
        .alu_gnt   (alu_gnt),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .valid     (valid),
        .busy      (busy)
    );

    // Behavioural alu: subtract only when asked to.
    assign alu_c = (alu_op == 4'd1) ? (alu_a - alu_b) : 32'h0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                check32("quotient", quotient, e.q);
                check32("remainder", remainder, e.r);
                check32("dbz", {31'b0, dbz}, {31'b0, e.dz});
                check32("valid_cycle", cyc, e.at);
            end
        end
    end

    // Issue one start; cycle numbers are counted in edges since time zero.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input int lat, output int t0);
        exp_t e;
        @(negedge clk);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        t0        = cyc;
        if (push) begin
            e.q  = eq;
            e.r  = er;
            e.dz = ed;
            e.at = t0 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        // Scramble inputs so unlatched operands would corrupt the result.
        is_signed = ~sg;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
        #1;
        check32("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int p0);
        int n;
        n = 0;
        while (pops == p0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pops == p0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no valid within 200 cycles (cycle %0d)", cyc);
        end else begin
            @(negedge clk);
            #1;
            check32("busy_after_done", {31'b0, busy}, 32'd0);
            check32("valid_one_cycle", {31'b0, valid}, 32'd0);
        end
    endtask

    task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ed,
                       input int lat);
        int p0;
        int t0;
        p0 = pops;
        issue(sg, a, b, 1'b1, eq, er, ed, lat, t0);
        wait_done(p0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          p0;
        logic [31:0] cap_a;
        logic [31:0] cap_b;

        repeat (3) @(negedge clk);
        #1;
        check32("rst_quotient", quotient, 32'h0);
        check32("rst_remainder", remainder, 32'h0);
        check32("rst_flags", {28'b0, dbz, valid, busy, alu_req}, 32'h0);
        check32("rst_alu_op", {28'b0, alu_op}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Unsigned: 100 = 7*14 + 2, valid 33 cycles after the start edge.
        run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        // 0xFFFFFFFF - 0x80000001 = 0x7FFFFFFE
        run(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);

        // Signed, truncating: -7 = 2*(-3) + (-1)
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 37);
        // 7 = (-2)*(-3) + 1
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 37);
        // -100 = (-7)*14 + (-2)
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 37);
        // Overflow case wraps to the dividend.
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 37);

        // Divide by zero in both modes, then a normal divide clears dbz.
        run(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Three ungranted cycles late in the loop, then a start while busy.
        p0 = pops;
        issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 36, t0);
        while (cyc != t0 + 30) @(negedge clk);
        alu_gnt = 1'b0;
        #1;
        cap_a = alu_a;
        cap_b = alu_b;
        check32("stall_alu_b_is_divisor", cap_b, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check32("stall_alu_a", alu_a, cap_a);
            check32("stall_alu_b", alu_b, cap_b);
            check32("stall_req_op", {27'b0, alu_req, alu_op}, 32'h11);
        end
        alu_gnt   = 1'b1;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(p0);

        // Reset in the middle of the loop (counter at 10) aborts without a valid.
        p0 = pops;
        issue(1'b0, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0, 0, t0);
        while (cyc != t0 + 22) @(negedge clk);
        resetn = 1'b0;
        #1;
        check32("abort_quotient", quotient, 32'h0);
        check32("abort_remainder", remainder, 32'h0);
        check32("abort_flags", {28'b0, dbz, valid, busy, alu_req}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check32("abort_no_valid", pops, p0);
        run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        check32("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
